boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  Upstream stage of cpu: streams a program image from an 8-bit byte source (UART RX or bench driver)
//  into the unified 256x16 RAM through its write port, then releases the CPU from reset.
//  Provides in hardware the clear+load sequence the cpu bench does with hierarchical writes.
//  Holds cpu in reset until a complete frame with a valid checksum has been written.
// PARAMETERS
//  ADDR_W         8      RAM address width; image addresses wrap mod 2**ADDR_W
//  DATA_W         16     RAM word width; fixed at 16 (two bytes per word), other values unsupported
//  SYNC_BYTE      8'hA5  frame header byte
//  CLEAR_ON_BOOT  1      1: zero all 2**ADDR_W words after reset before accepting a frame
//  LOAD_BASE      0      RAM address of first loaded word
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  in_data    in   8       byte stream data
//  in_valid   in   1       byte present; transfer when in_valid & in_ready at posedge
//  in_ready   out  1       loader can accept a byte this cycle
//  mem_we     out  1       RAM write strobe, one-cycle pulse per word
//  mem_addr   out  ADDR_W  RAM write address
//  mem_wdata  out  DATA_W  RAM write data
//  cpu_halt   in   1       cpu Halt output
//  cpu_reset  out  1       drives cpu reset; 1 = CPU held
//  load_done  out  1       last frame loaded and checksum good
//  load_err   out  1       last frame failed checksum
// BEHAVIOUR
//  Reset (sync, active-high): in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, load_done=0,
//   load_err=0; state=CLEAR if CLEAR_ON_BOOT else WAIT_HDR. Reset mid-frame aborts; no partial resume.
//  Frame: SYNC_BYTE, LEN (N words, 0..255), N x {HI byte, LO byte}, CSUM.
//   Good iff (LEN + all data bytes + CSUM) mod 256 == 0.
//  States:
//   CLEAR:    in_ready=0; mem_we=1 each cycle, addr 0..2**ADDR_W-1, wdata=0; after last addr -> WAIT_HDR.
//   WAIT_HDR: in_ready=1; SYNC_BYTE -> GET_LEN; any other byte dropped.
//   GET_LEN:  latch N, sum=N, word index=0; N==0 -> GET_CSUM else GET_HI.
//   GET_HI:   latch high byte -> GET_LO.
//   GET_LO:   next cycle mem_we=1, mem_addr=LOAD_BASE+idx (mod 2**ADDR_W), mem_wdata={HI,LO};
//             idx++; idx==N -> GET_CSUM else GET_HI. in_ready may stay 1 (write is registered, 1-cycle latency).
//   GET_CSUM: good -> RUN with cpu_reset=0, load_done=1, load_err=0 in the cycle after the CSUM transfer;
//             bad -> ERROR with load_err=1, load_done=0, cpu_reset=1.
//   RUN:      in_ready=cpu_halt (stream back-pressured while CPU executes). Accepted SYNC_BYTE -> cpu_reset=1
//             and load_done=0 next cycle, -> GET_LEN (no re-clear); other bytes dropped.
//   ERROR:    in_ready=1; behaves as WAIT_HDR; SYNC_BYTE clears load_err -> GET_LEN.
//  cpu_reset is 1 in every state except RUN; load_done/load_err never both 1.
//  in_valid gaps between any bytes are legal; state waits indefinitely (no timeout).
//  Data words are written before checksum is known; bad frame leaves RAM dirty, CPU held.
//  mem_addr/mem_wdata hold last value when mem_we=0. No RAM read port.
// STRUCTURE
//  boot_defs.vh (shared `include): state encodings, default SYNC_BYTE, frame-format constants.
//  Sub-module boot_word_asm: HI/LO byte pairing, running 8-bit checksum, word index counter;
//   boot_loader keeps FSM, CLEAR counter, RAM write register, cpu_reset/status flags.
//  At top level, RAM write-port mux selects loader while cpu_reset=1, datapath otherwise (outside block).
// TESTING
//  1 Reset, CLEAR_ON_BOOT=1 -> 256 consecutive mem_we pulses, addr 00..FF, wdata 0000; then in_ready=1, cpu_reset=1.
//  2 Send A5 03 12 34 AB CD 00 08 37 -> writes [00]=1234 [01]=ABCD [02]=0008; cycle after 37: cpu_reset=0, load_done=1.
//  3 Same frame, CSUM 38 -> same 3 writes, load_err=1, load_done=0, cpu_reset stays 1; then good frame -> load_err=0.
//  4 Junk 00 FF 5A before A5, random in_valid bubbles between HI and LO -> junk dropped, result identical to 2.
//  5 Send A5 00 00 -> no mem_we, load_done=1, cpu_reset=0 next cycle.
//  6 In RUN, cpu_halt=0: in_ready=0; cpu_halt=1 then A5 01 00 08 F7 -> cpu_reset=1, [00]=0008, released again.
//  7 Assert reset during GET_LO -> no write for pending word; CLEAR restarts from addr 00, flags at reset values.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and frame-format widths.
package boot_loader_pkg;

  localparam int          BYTE_W        = 8;
  localparam int          LEN_W         = 8;
  localparam int          WORD_W        = 2 * BYTE_W;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_WAIT_HDR,
    ST_GET_LEN,
    ST_GET_HI,
    ST_GET_LO,
    ST_GET_CSUM,
    ST_RUN,
    ST_ERROR
  } boot_state_e;

  // States in which a sync byte opens a new frame.
  function automatic logic hunts_sync(boot_state_e s);
    return (s == ST_WAIT_HDR) || (s == ST_ERROR) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Frame payload assembler: pairs HI/LO bytes into words, keeps the running checksum and word index.
module boot_word_asm
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              len_ld,
  input  logic              hi_ld,
  input  logic              lo_ld,
  output logic [WORD_W-1:0] word,
  output logic [LEN_W-1:0]  word_idx,
  output logic              last_word,
  output logic              csum_good
);

  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] hi_q,  hi_d;
  logic [BYTE_W-1:0] sum_q, sum_d;

  always_comb begin
    len_d = len_q;
    idx_d = idx_q;
    hi_d  = hi_q;
    sum_d = sum_q;
    if (len_ld) begin
      len_d = in_byte;
      sum_d = in_byte;
      idx_d = '0;
    end
    if (hi_ld) begin
      hi_d  = in_byte;
      sum_d = sum_q + in_byte;
    end
    if (lo_ld) begin
      sum_d = sum_q + in_byte;
      idx_d = idx_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
      idx_q <= '0;
      hi_q  <= '0;
      sum_q <= '0;
    end else begin
      len_q <= len_d;
      idx_q <= idx_d;
      hi_q  <= hi_d;
      sum_q <= sum_d;
    end
  end

  // Word and status are combinational on the byte being transferred this cycle.
  assign word      = {hi_q, in_byte};
  assign word_idx  = idx_q;
  assign last_word = ({1'b0, idx_q} + 9'd1) == {1'b0, len_q};
  assign csum_good = 8'(sum_q + in_byte) == 8'd0;

endmodule

// File: rtl/boot_loader.sv
// Streams a framed program image into RAM through its write port, then releases the CPU from reset.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         ADDR_W        = 8,
  parameter int         DATA_W        = 16,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter bit         CLEAR_ON_BOOT = 1'b1,
  parameter int         LOAD_BASE     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              cpu_halt,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam boot_state_e ST_BOOT = CLEAR_ON_BOOT ? ST_CLEAR : ST_WAIT_HDR;

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              xfer;
  logic [WORD_W-1:0] word;
  logic [LEN_W-1:0]  word_idx;
  logic              last_word;
  logic              csum_good;

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_CLEAR: in_ready = 1'b0;
        ST_RUN:   in_ready = cpu_halt;
        default:  in_ready = 1'b1;
      endcase
    end
  end

  assign xfer = in_valid && in_ready;

  boot_word_asm u_word_asm (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_data),
    .len_ld    (xfer && (state_q == ST_GET_LEN)),
    .hi_ld     (xfer && (state_q == ST_GET_HI)),
    .lo_ld     (xfer && (state_q == ST_GET_LO)),
    .word      (word),
    .word_idx  (word_idx),
    .last_word (last_word),
    .csum_good (csum_good)
  );

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;

    if (hunts_sync(state_q)) begin
      // A new frame re-holds the CPU and clears both status flags.
      if (xfer && (in_data == SYNC_BYTE)) begin
        state_d     = ST_GET_LEN;
        cpu_reset_d = 1'b1;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_CLEAR: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = clr_q;
          mem_wdata_d = '0;
          clr_d       = clr_q + 1'b1;
          if (clr_q == '1) state_d = ST_WAIT_HDR;
        end
        ST_GET_LEN: if (xfer) state_d = (in_data == 8'd0) ? ST_GET_CSUM : ST_GET_HI;
        ST_GET_HI:  if (xfer) state_d = ST_GET_LO;
        ST_GET_LO: begin
          if (xfer) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_W'(LOAD_BASE) + ADDR_W'(word_idx);
            mem_wdata_d = DATA_W'(word);
            state_d     = last_word ? ST_GET_CSUM : ST_GET_HI;
          end
        end
        ST_GET_CSUM: begin
          if (xfer) begin
            state_d     = csum_good ? ST_RUN : ST_ERROR;
            cpu_reset_d = !csum_good;
            load_done_d = csum_good;
            load_err_d  = !csum_good;
          end
        end
        default: state_d = ST_WAIT_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      clr_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: expected RAM writes go to a scoreboard queue, a monitor pops on mem_we.
module tb_boot_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_halt = 1'b0;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  int  checks = 0;
  int  errors = 0;
  wr_t wq[$];

  always #5 clk = ~clk;

  boot_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_halt  (cpu_halt),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_err  (load_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        chk("wr_data", {16'd0, mem_wdata}, {16'd0, e.data});
      end
    end
  end

  task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] f[$], input bit bubbles);
    foreach (f[i]) begin
      send_byte(f[i]);
      if (bubbles) idle($urandom_range(0, 3));
    end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (wq.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, wq.size(), 32'd0);
  endtask

  task automatic chk_flags(input string nm, input logic rst, input logic done, input logic err);
    chk({nm, "_cpu_reset"}, 32'(cpu_reset), 32'(rst));
    chk({nm, "_load_done"}, 32'(load_done), 32'(done));
    chk({nm, "_load_err"},  32'(load_err),  32'(err));
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_in_ready"},  32'(in_ready), 32'd0);
    chk({nm, "_mem_we"},    32'(mem_we), 32'd0);
    chk({nm, "_mem_addr"},  32'(mem_addr), 32'd0);
    chk({nm, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk_flags(nm, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clear_and_release(input string nm);
    for (int i = 0; i < 256; i++) push_wr(8'(i), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    drain({nm, "_clear_drain"});
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk_flags(nm, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // 1: reset values, then full RAM clear
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    clear_and_release("boot");

    // 2: good three-word frame
    push_wr(8'h00, 16'h1234);
    push_wr(8'h01, 16'hABCD);
    push_wr(8'h02, 16'h0008);
    send_seq('{8'hA5, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h08, 8'h37}, 1'b0);
    chk_flags("good", 1'b0, 1'b1, 1'b0);
    drain("good_drain");
    @(negedge clk);
    chk("run_halt0_in_ready", 32'(in_ready), 32'd0);

    // 3: same frame with bad checksum
    cpu_halt = 1'b1;
    push_wr(8'h00, 16'h1234);
    push_wr(8'h01, 16'hABCD);
    push_wr(8'h02, 16'h0008);
    send_byte(8'hA5);
    chk_flags("resync", 1'b1, 1'b0, 1'b0);
    send_seq('{8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h08, 8'h38}, 1'b0);
    chk_flags("bad", 1'b1, 1'b0, 1'b1);
    drain("bad_drain");
    cpu_halt = 1'b0;
    @(negedge clk);
    chk("error_in_ready", 32'(in_ready), 32'd1);

    // 4: junk before sync, bubbles everywhere
    send_seq('{8'h00, 8'hFF, 8'h5A}, 1'b1);
    chk_flags("junk", 1'b1, 1'b0, 1'b1);
    push_wr(8'h00, 16'h1234);
    push_wr(8'h01, 16'hABCD);
    push_wr(8'h02, 16'h0008);
    send_byte(8'hA5);
    chk_flags("err_clear", 1'b1, 1'b0, 1'b0);
    send_seq('{8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h08, 8'h37}, 1'b1);
    chk_flags("good_bubbles", 1'b0, 1'b1, 1'b0);
    drain("bubbles_drain");

    // 5: empty frame, no writes
    cpu_halt = 1'b1;
    @(negedge clk);
    chk("run_halt1_in_ready", 32'(in_ready), 32'd1);
    send_seq('{8'hA5, 8'h00}, 1'b0);
    chk_flags("empty_len", 1'b1, 1'b0, 1'b0);
    send_byte(8'h00);
    chk_flags("empty", 1'b0, 1'b1, 1'b0);
    idle(3);

    // 6: reload from RUN
    push_wr(8'h00, 16'h0008);
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h08, 8'hF7}, 1'b0);
    chk_flags("reload", 1'b0, 1'b1, 1'b0);
    drain("reload_drain");

    // 7: reset while the second word's LO byte transfers
    push_wr(8'h00, 16'h1122);
    send_seq('{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33}, 1'b0);
    drain("pre_abort_drain");
    @(negedge clk);
    in_data  = 8'h44;
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_reset_state("abort");
    clear_and_release("reboot");
    idle(4);
    chk("final_queue", wq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
